// File: rtl/matrix_pkg.sv
// Shared types and derived widths for the matrix deserializer and compiler.
// Default sizes also serve as parameter defaults for the top level.
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } rx_state_t;

    localparam int DEF_ELEMENT_SIZE = 8;
    localparam int DEF_SIZE_A       = 32;
    localparam int DEF_SIZE_B       = 32;
    localparam int DEF_TIMEOUT      = 4096;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ELEM_DIBITS = DEF_ELEMENT_SIZE / 2;
    localparam int DCNT_W      = width_of(ELEM_DIBITS);
    localparam int ECNT_W      = width_of(DEF_SIZE_A * DEF_SIZE_B);
    localparam int ROW_W       = width_of(DEF_SIZE_A);
    localparam int COL_W       = width_of(DEF_SIZE_B);

endpackage

// File: rtl/dibit_shifter.sv
// MSB-first dibit shift register with a per-element dibit counter.
// byte_out is the element as it would look with the current dibit shifted in.
import matrix_pkg::*;

module dibit_shifter #(
    parameter int W = DEF_ELEMENT_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [1:0]   dibit,
    output logic [W-1:0] byte_out,
    output logic         byte_valid,
    output logic         mid_elem
);

    localparam int ND = W / 2;
    localparam int DW = width_of(ND);
    localparam logic [DW-1:0] DLAST = DW'(ND - 1);

    logic [W-1:0]  shift_q, shift_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    always_comb begin
        byte_out   = (shift_q << 2) | W'(dibit);
        byte_valid = load && (dcnt_q == DLAST);
        mid_elem   = (dcnt_q != '0);
        shift_d    = shift_q;
        dcnt_d     = dcnt_q;
        if (clear) begin
            shift_d = '0;
            dcnt_d  = '0;
        end else if (load) begin
            shift_d = byte_out;
            dcnt_d  = (dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            dcnt_q  <= '0;
        end else begin
            shift_q <= shift_d;
            dcnt_q  <= dcnt_d;
        end
    end

endmodule

// File: rtl/matrix_deserializer.sv
// Requests a matrix and rebuilds row-major elements from a dibit stream,
// tagging each with its row/column address for a downstream matrix store.
import matrix_pkg::*;

module matrix_deserializer #(
    parameter int MAX_ELEMENT_SIZE = DEF_ELEMENT_SIZE,
    parameter int MAX_SIZE_A       = DEF_SIZE_A,
    parameter int MAX_SIZE_B       = DEF_SIZE_B,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT
) (
    input  logic                          eth_refclk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          valid_data_in,
    input  logic [1:0]                    dibit,
    output logic                          data_request,
    output logic                          valid_data_out,
    output logic [$clog2(MAX_SIZE_A)-1:0] row_addr,
    output logic [$clog2(MAX_SIZE_B)-1:0] col_addr,
    output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
    output logic                          matrix_done,
    output logic                          rx_error
);

    localparam int RW = $clog2(MAX_SIZE_A);
    localparam int CW = $clog2(MAX_SIZE_B);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = MAX_ELEMENT_SIZE;
    localparam logic [RW-1:0] ROW_LAST = RW'(MAX_SIZE_A - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(MAX_SIZE_B - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    if ((MAX_ELEMENT_SIZE % 2) != 0) begin : g_odd_elem
        $error("MAX_ELEMENT_SIZE must be even");
    end

    rx_state_t     state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_q, req_d;
    logic          vld_q, vld_d;
    logic [RW-1:0] raddr_q, raddr_d;
    logic [CW-1:0] caddr_q, caddr_d;
    logic [EW-1:0] elem_q, elem_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          shf_load, shf_clear;
    logic [EW-1:0] shf_byte;
    logic          shf_valid, shf_mid;

    dibit_shifter #(.W(EW)) u_shifter (
        .clk        (eth_refclk),
        .rst        (rst),
        .load       (shf_load),
        .clear      (shf_clear),
        .dibit      (dibit),
        .byte_out   (shf_byte),
        .byte_valid (shf_valid),
        .mid_elem   (shf_mid)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tmo_d     = tmo_q;
        req_d     = 1'b0;
        vld_d     = 1'b0;
        raddr_d   = raddr_q;
        caddr_d   = caddr_q;
        elem_d    = elem_q;
        done_d    = 1'b0;
        err_d     = err_q;
        shf_load  = 1'b0;
        shf_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req_d     = 1'b1;
                    err_d     = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    tmo_d     = '0;
                    shf_clear = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT, ST_RECV: begin
                if (valid_data_in) begin
                    shf_load = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_RECV;
                    if (shf_valid) begin
                        vld_d   = 1'b1;
                        elem_d  = shf_byte;
                        raddr_d = row_q;
                        caddr_d = col_q;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                            if (row_q == ROW_LAST) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else if (shf_mid) begin
                    // partial element is dropped, never strobed
                    err_d     = 1'b1;
                    shf_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge eth_refclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            raddr_q <= '0;
            caddr_q <= '0;
            elem_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            raddr_q <= raddr_d;
            caddr_q <= caddr_d;
            elem_q  <= elem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_request   = req_q;
    assign valid_data_out = vld_q;
    assign row_addr       = raddr_q;
    assign col_addr       = caddr_q;
    assign matrix_element = elem_q;
    assign matrix_done    = done_q;
    assign rx_error       = err_q;

endmodule

// File: tb/tb_matrix_deserializer.sv
// Directed bench for matrix_deserializer at default parameters.
// A negedge monitor logs strobes and pulses; checks compare against fixed values.
module tb_matrix_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       vin;
    logic [1:0] dibit;
    logic       dr;
    logic       vout;
    logic [4:0] row;
    logic [4:0] col;
    logic [7:0] elem;
    logic       done;
    logic       err;

    matrix_deserializer dut (
        .eth_refclk     (clk),
        .rst            (rst),
        .start          (start),
        .valid_data_in  (vin),
        .dibit          (dibit),
        .data_request   (dr),
        .valid_data_out (vout),
        .row_addr       (row),
        .col_addr       (col),
        .matrix_element (elem),
        .matrix_done    (done),
        .rx_error       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    logic [7:0] s_elem [2048];
    logic [4:0] s_row  [2048];
    logic [4:0] s_col  [2048];
    int ns = 0, ndone = 0, ndr = 0, novl = 0;
    int cyc = 0, str_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (vout === 1'b1) begin
            if (ns < 2048) begin
                s_elem[ns] = elem;
                s_row[ns]  = row;
                s_col[ns]  = col;
            end
            ns++;
            str_cyc = cyc;
        end
        if (done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
            if (vout === 1'b1) novl++;
        end
        if (dr === 1'b1) ndr++;
    end

    task automatic clr_mon();
        ns = 0; ndone = 0; ndr = 0; novl = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_dibit(input logic [1:0] d);
        vin   = 1'b1;
        dibit = d;
        step();
    endtask

    task automatic send_elem(input logic [7:0] v);
        send_dibit(v[7:6]);
        send_dibit(v[5:4]);
        send_dibit(v[3:2]);
        send_dibit(v[1:0]);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, dr, vout, row, col, elem, done, err};
    endfunction

    initial begin
        int bad;
        logic [7:0] ev;
        rst = 1'b1; start = 1'b0; vin = 1'b0; dibit = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'd0);
        rst = 1'b0;
        step();

        // dibit order, then a gap mid-element
        clr_mon();
        do_start();
        check("req_pulse", {31'd0, dr}, 32'd1);
        send_dibit(2'b11);
        check("req_clears", {31'd0, dr}, 32'd0);
        send_dibit(2'b00);
        send_dibit(2'b10);
        check("no_early_strobe", {31'd0, vout}, 32'd0);
        send_dibit(2'b01);
        check("order_strobe", {31'd0, vout}, 32'd1);
        check("order_elem", {24'd0, elem}, 32'h0000_00C9);
        check("order_addr", {22'd0, row, col}, 32'd0);
        send_dibit(2'b01);
        send_dibit(2'b10);
        idle(1);
        check("gap_err", {31'd0, err}, 32'd1);
        send_elem(8'h5A);
        idle(2);
        check("gap_no_strobe", ns, 32'd1);
        check("gap_err_sticky", {31'd0, err}, 32'd1);
        clr_mon();
        do_start();
        check("start_clr_err", {31'd0, err}, 32'd0);

        // pause at an element boundary
        for (int k = 0; k < 6; k++) send_elem(8'(8'h10 + k));
        idle(10);
        send_elem(8'h16);
        send_elem(8'h17);
        idle(2);
        check("pause_no_err", {31'd0, err}, 32'd0);
        check("pause_count", ns, 32'd8);
        check("pause_e6", {14'd0, s_row[6], s_col[6], s_elem[6]},
              {14'd0, 5'd0, 5'd6, 8'h16});
        check("pause_e7", {14'd0, s_row[7], s_col[7], s_elem[7]},
              {14'd0, 5'd0, 5'd7, 8'h17});
        send_dibit(2'b11);
        idle(1);

        // timeout with no data
        clr_mon();
        do_start();
        vin = 1'b0;
        repeat (4095) step();
        check("tmo_not_yet", {31'd0, err}, 32'd0);
        step();
        check("tmo_err", {31'd0, err}, 32'd1);
        idle(2);
        check("tmo_req_once", ndr, 32'd1);
        check("tmo_no_strobe", ns, 32'd0);

        // full frame
        clr_mon();
        do_start();
        for (int k = 0; k < 1024; k++) send_elem(8'(k));
        idle(3);
        check("frame_count", ns, 32'd1024);
        check("frame_e33", {14'd0, s_row[33], s_col[33], s_elem[33]},
              {14'd0, 5'd1, 5'd1, 8'h21});
        check("frame_last", {14'd0, s_row[1023], s_col[1023], s_elem[1023]},
              {14'd0, 5'd31, 5'd31, 8'hFF});
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            ev = 8'(i);
            if (s_elem[i] !== ev || s_row[i] !== 5'(i / 32) ||
                s_col[i] !== 5'(i % 32)) bad++;
        end
        check("frame_data", bad, 32'd0);
        check("done_once", ndone, 32'd1);
        check("done_after_last", done_cyc - str_cyc, 32'd1);
        check("done_no_overlap", novl, 32'd0);
        check("frame_no_err", {31'd0, err}, 32'd0);
        check("elem_holds", {24'd0, elem}, 32'h0000_00FF);

        // async reset mid-frame
        clr_mon();
        do_start();
        for (int k = 0; k < 500; k++) send_elem(8'(k));
        check("pre_rst_e499", {14'd0, row, col, elem},
              {14'd0, 5'd15, 5'd19, 8'hF3});
        #2;
        rst = 1'b1;
        vin = 1'b0;
        #1;
        check("rst_async_outs", outs(), 32'd0);
        step();
        rst = 1'b0;
        idle(3);
        check("rst_no_done", ndone, 32'd0);
        clr_mon();
        do_start();
        send_elem(8'hAB);
        check("restart_e0", {14'd0, row, col, elem},
              {14'd0, 5'd0, 5'd0, 8'hAB});
        check("restart_strobe", {31'd0, vout}, 32'd1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
